approx_product_accumulator: RTL and testbench
=============================================

Name: approx_product_accumulator

Overview:
- Downstream consumer of the 16x16 approximate multiplier.
- Accepts a stream of 32-bit approximate products over a valid/ready handshake.
- Accumulates each frame of up to LEN products into a wide accumulator and presents the frame sum on an output valid/ready handshake.
- Used for approximate dot products and MAC-based error characterisation of the multiplier schemes.

Parameters:
- PW, 32, product input width (matches multiplier output y).
- AW, 40, accumulator and result width; must satisfy AW >= PW.
- LEN, 8, maximum products per frame; must be >= 1.
- CW, $clog2(LEN+1), width of the product counter and out_count.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  product available
- in_ready  output  1  block can accept a product this cycle
- in_prod  input  PW  approximate product, unsigned
- in_last  input  1  qualifies in_prod as the final product of the frame (early termination)
- out_valid  output  1  frame result available
- out_ready  input  1  consumer takes the result
- out_sum  output  AW  accumulated frame sum, unsigned
- out_count  output  CW  number of products in the frame (1..LEN)
- out_ovf  output  1  sticky: accumulator exceeded 2^AW-1 during this frame

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values:
  - state=IDLE, acc=0, cnt=0, ovf=0.
  - in_ready=1 after reset release; out_valid=0, out_sum=0, out_count=0, out_ovf=0.
- Accept event = in_valid && in_ready. Result handshake = out_valid && out_ready.
- Registered FSM with three states:
  - IDLE:
    - in_ready=1, out_valid=0.
    - On accept: acc <= zero-extend(in_prod), cnt <= 1, ovf <= 0.
    - Go to DONE if in_last or LEN==1; otherwise go to ACC.
  - ACC:
    - in_ready=1, out_valid=0.
    - On accept: acc <= acc + zero-extend(in_prod), cnt <= cnt+1.
    - Go to DONE if in_last or cnt+1==LEN.
    - No accept: hold all state.
  - DONE:
    - in_ready=0, out_valid=1.
    - out_sum=acc, out_count=cnt, out_ovf=ovf; all held stable while out_ready=0.
    - On handshake: acc <= 0, cnt <= 0, ovf <= 0, go to IDLE.
- Latency:
  - out_valid rises the cycle after the final product is accepted.
  - Minimum one bubble cycle between frames: no input is accepted in DONE.
- Arithmetic and overflow:
  - Addition is AW+1 bits wide. A carry-out sets ovf, which stays set until the frame result handshake.
  - Without the saturation feature, acc keeps the low AW bits (wrap).
- Boundary conditions:
  - in_last asserted together with the LEN-th product: one transition to DONE, no double count.
  - in_last with the first product: single-product frame, out_count=1.
  - in_valid while in DONE: ignored, and in_prod is not consumed (in_ready=0).
  - Async reset mid-frame or in DONE: partial sum discarded, all outputs return to reset values immediately.
- Outputs are driven from registers only; there is no combinational path from in_* to out_*.
- in_ready depends on state only, never on in_valid.

Optional Feature:
- Macro: APPROX_ACC_SAT_EN.
- Defined:
  - On carry-out, acc clamps to 2^AW-1 and remains there for the rest of the frame.
  - ovf is still set.
- Undefined: wrap-around accumulation as described above; ovf is still set.

Decomposition:
- Shared package approx_pkg holds:
  - state enum acc_state_t {IDLE, ACC, DONE};
  - default widths PW_DEF=32 and AW_DEF=40;
  - localparam function for CW.
- No sub-module is needed; the adder/saturation logic stays inline as one always block.

Test Plan:
- Reset, then 8 products of 1000 each, out_ready=1 → out_valid rises one cycle after the 8th accept; out_sum=8000, out_count=8, out_ovf=0.
- Products 5, 7, 9 with in_last on 9 → out_sum=21, out_count=3; in_ready=0 in the cycle out_valid=1.
- out_ready held 0 for 5 cycles in DONE while in_valid=1 with in_prod=0xDEAD → out_sum stable, no product accepted; the next frame starts only after the handshake.
- AW=33, two products of 0xFFFFFFFF then 0x2 in one frame → carry-out of 33 bits:
  - without APPROX_ACC_SAT_EN: out_sum=0x000000000, out_ovf=1;
  - with APPROX_ACC_SAT_EN: out_sum=0x1FFFFFFFF, out_ovf=1.
- Assert rst_n low asynchronously after 4 of 8 products accepted → outputs zero immediately; the following full frame of 8x3 gives out_sum=24.
- LEN=1 build, in_prod=42 with in_last=0 → out_sum=42, out_count=1 in the next cycle.

Source files
------------

// File: rtl/approx_product_accumulator_pkg.sv
// ---------------------------------------------------------------------------
// approx_pkg
// Shared definitions for the approximate-product accumulator:
//   - acc_state_t : frame FSM states (IDLE, ACC, DONE)
//   - PW_DEF/AW_DEF : default product and accumulator widths
//   - cnt_width() : width needed to count 0..LEN products
// ---------------------------------------------------------------------------
package approx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } acc_state_t;

    localparam int PW_DEF = 32;
    localparam int AW_DEF = 40;

    // Product counter must hold the value LEN itself, hence LEN+1 codes.
    function automatic int cnt_width(input int len);
        return $clog2(len + 1);
    endfunction

endpackage

// File: rtl/approx_product_accumulator.sv
// ---------------------------------------------------------------------------
// approx_product_accumulator
// Sums frames of up to LEN unsigned approximate products (from the 16x16
// approximate multiplier) and hands each frame sum downstream.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   product available
//   in_ready   block can accept a product (depends on state only)
//   in_prod    PW-bit unsigned product
//   in_last    marks the final product of a frame (early termination)
//   out_valid  frame result available
//   out_ready  consumer takes the result
//   out_sum    AW-bit frame sum
//   out_count  number of products in the frame (1..LEN)
//   out_ovf    sticky: sum exceeded 2^AW-1 during the frame
//
// Build option:
//   APPROX_ACC_SAT_EN  when defined, a carry-out clamps the accumulator to
//                      2^AW-1 instead of wrapping; out_ovf is set either way.
// ---------------------------------------------------------------------------
module approx_product_accumulator
    import approx_pkg::*;
#(
    parameter int PW  = PW_DEF,
    parameter int AW  = AW_DEF,
    parameter int LEN = 8,
    parameter int CW  = cnt_width(LEN)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [PW-1:0] in_prod,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] out_sum,
    output logic [CW-1:0] out_count,
    output logic          out_ovf
);

    acc_state_t    state_reg;
    logic [AW-1:0] acc_reg;
    logic [CW-1:0] cnt_reg;
    logic          ovf_reg;
    logic          in_ready_reg;
    logic          out_valid_reg;

    logic [AW-1:0] prod_ext;
    logic [AW:0]   sum_ext;
    logic          carry;
    logic [AW-1:0] acc_next;
    logic          accept;
    logic          final_beat;

    assign accept = in_valid && in_ready_reg;

    // One extra bit on the adder captures the carry-out that flags overflow.
    always_comb begin
        prod_ext = AW'(in_prod);
        sum_ext  = {1'b0, acc_reg} + {1'b0, prod_ext};
        carry    = sum_ext[AW];
`ifdef APPROX_ACC_SAT_EN
        // Once clamped, any further non-zero product carries again, so the
        // accumulator stays pinned at full scale for the rest of the frame.
        acc_next = carry ? {AW{1'b1}} : sum_ext[AW-1:0];
`else
        acc_next = sum_ext[AW-1:0];
`endif
        // cnt_reg is the count before this product; LEN-1 means this is LEN-th.
        final_beat = in_last || (cnt_reg == CW'(LEN - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            acc_reg       <= '0;
            cnt_reg       <= '0;
            ovf_reg       <= 1'b0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        // First product loads the accumulator; no carry possible.
                        acc_reg <= prod_ext;
                        cnt_reg <= CW'(1);
                        ovf_reg <= 1'b0;
                        if (in_last || (LEN == 1)) begin
                            state_reg     <= DONE;
                            in_ready_reg  <= 1'b0;
                            out_valid_reg <= 1'b1;
                        end else begin
                            state_reg <= ACC;
                        end
                    end
                end
                ACC: begin
                    if (accept) begin
                        acc_reg <= acc_next;
                        cnt_reg <= cnt_reg + CW'(1);
                        ovf_reg <= ovf_reg | carry;
                        if (final_beat) begin
                            state_reg     <= DONE;
                            in_ready_reg  <= 1'b0;
                            out_valid_reg <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        acc_reg       <= '0;
                        cnt_reg       <= '0;
                        ovf_reg       <= 1'b0;
                        state_reg     <= IDLE;
                        in_ready_reg  <= 1'b1;
                        out_valid_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    in_ready_reg  <= 1'b1;
                    out_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    // All outputs come straight from registers.
    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign out_sum   = acc_reg;
    assign out_count = cnt_reg;
    assign out_ovf   = ovf_reg;

endmodule

// File: tb/tb_approx_product_accumulator.sv
// ---------------------------------------------------------------------------
// tb_approx_product_accumulator
// Directed bench for approx_product_accumulator. Three instances share the
// clock and reset:
//   0 : default build (PW=32, AW=40, LEN=8)
//   1 : narrow accumulator (AW=33) for carry-out / overflow behaviour
//   2 : single-product frames (LEN=1)
// Expected frame results are queued when a frame is driven and popped when
// the selected instance presents its result.
// ---------------------------------------------------------------------------
module tb_approx_product_accumulator;

    typedef struct {
        logic [39:0] sum;
        logic [3:0]  cnt;
        logic        ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  in_valid;
    logic [2:0]  in_last;
    logic [2:0]  out_ready;
    logic [31:0] in_prod [3];

    wire  [2:0]  in_ready;
    wire  [2:0]  out_valid;
    wire  [2:0]  out_ovf;
    wire  [39:0] sum0;
    wire  [32:0] sum1;
    wire  [39:0] sum2;
    wire  [3:0]  cnt0;
    wire  [3:0]  cnt1;
    wire         cnt2;

    exp_t sb[$];
    int   checks = 0;
    int   passed = 0;
    int   fails  = 0;

    always #5 clk = ~clk;

    approx_product_accumulator #(.PW(32), .AW(40), .LEN(8)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_prod(in_prod[0]), .in_last(in_last[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_sum(sum0), .out_count(cnt0), .out_ovf(out_ovf[0])
    );

    approx_product_accumulator #(.PW(32), .AW(33), .LEN(8)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_prod(in_prod[1]), .in_last(in_last[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_sum(sum1), .out_count(cnt1), .out_ovf(out_ovf[1])
    );

    approx_product_accumulator #(.PW(32), .AW(40), .LEN(1)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_prod(in_prod[2]), .in_last(in_last[2]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .out_sum(sum2), .out_count(cnt2), .out_ovf(out_ovf[2])
    );

    function automatic logic [39:0] get_sum(input int s);
        case (s)
            0:       return sum0;
            1:       return {7'b0, sum1};
            default: return sum2;
        endcase
    endfunction

    function automatic logic [3:0] get_cnt(input int s);
        case (s)
            0:       return cnt0;
            1:       return cnt1;
            default: return {3'b0, cnt2};
        endcase
    endfunction

    task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Present one product (at a negedge) and return at the negedge after
    // the clock edge that accepted it.
    task automatic send(input int s, input logic [31:0] p, input logic l);
        int n = 0;
        in_valid[s] = 1'b1;
        in_prod[s]  = p;
        in_last[s]  = l;
        while (!in_ready[s] && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("send_ready", {39'b0, in_ready[s]}, 40'd1);
        @(negedge clk);
    endtask

    task automatic drop(input int s);
        in_valid[s] = 1'b0;
        in_last[s]  = 1'b0;
    endtask

    // Wait for a frame result, compare it against the scoreboard, handshake.
    task automatic collect(input int s, input string tag);
        exp_t e;
        int   n = 0;
        while (!out_valid[s] && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, {39'b0, out_valid[s]}, 40'd1);
        check({tag, "_sb_nonempty"}, 40'(sb.size() > 0), 40'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            $display("frame %s dut%0d: sum=0x%0h count=%0d ovf=%0b (expect sum=0x%0h count=%0d ovf=%0b)",
                     tag, s, get_sum(s), get_cnt(s), out_ovf[s], e.sum, e.cnt, e.ovf);
            check({tag, "_sum"},   get_sum(s),              e.sum);
            check({tag, "_count"}, {36'b0, get_cnt(s)},     {36'b0, e.cnt});
            check({tag, "_ovf"},   {39'b0, out_ovf[s]},     {39'b0, e.ovf});
            check({tag, "_in_ready_low"}, {39'b0, in_ready[s]}, 40'd0);
        end
        out_ready[s] = 1'b1;
        @(negedge clk);
        out_ready[s] = 1'b0;
        check({tag, "_released"}, {39'b0, out_valid[s]}, 40'd0);
    endtask

    initial begin
        logic [39:0] held;
        rst_n     = 1'b0;
        in_valid  = '0;
        in_last   = '0;
        out_ready = '0;
        for (int i = 0; i < 3; i++) in_prod[i] = '0;

        // Reset state
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready",  {39'b0, in_ready[0]},  40'd1);
        check("rst_out_valid", {39'b0, out_valid[0]}, 40'd0);
        check("rst_sum",       sum0,                  40'd0);
        check("rst_count",     {36'b0, cnt0},         40'd0);
        check("rst_ovf",       {39'b0, out_ovf[0]},   40'd0);

        // Full frame: 8 x 1000, terminated by LEN
        for (int i = 0; i < 8; i++) begin
            if (i == 7) check("t1_not_early", {39'b0, out_valid[0]}, 40'd0);
            send(0, 32'd1000, 1'b0);
        end
        check("t1_latency", {39'b0, out_valid[0]}, 40'd1);
        drop(0);
        sb.push_back('{sum: 40'd8000, cnt: 4'd8, ovf: 1'b0});
        collect(0, "t1");

        // Early termination: 5, 7, 9(last)
        send(0, 32'd5, 1'b0);
        send(0, 32'd7, 1'b0);
        send(0, 32'd9, 1'b1);
        check("t2_latency", {39'b0, out_valid[0]}, 40'd1);
        check("t2_ready",   {39'b0, in_ready[0]},  40'd0);
        drop(0);
        sb.push_back('{sum: 40'd21, cnt: 4'd3, ovf: 1'b0});
        collect(0, "t2");

        // Backpressure in DONE with a product waiting
        send(0, 32'd100, 1'b1);
        in_valid[0] = 1'b1;
        in_prod[0]  = 32'hDEAD;
        in_last[0]  = 1'b1;
        held = sum0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t3_stall_sum",   sum0,                  held);
            check("t3_stall_ready", {39'b0, in_ready[0]},  40'd0);
            check("t3_stall_valid", {39'b0, out_valid[0]}, 40'd1);
        end
        sb.push_back('{sum: 40'd100, cnt: 4'd1, ovf: 1'b0});
        collect(0, "t3a");
        // The waiting product is taken only now, once, as a new frame.
        @(negedge clk);
        drop(0);
        sb.push_back('{sum: 40'hDEAD, cnt: 4'd1, ovf: 1'b0});
        collect(0, "t3b");

        // Asynchronous reset mid-frame
        for (int i = 0; i < 4; i++) send(0, 32'd500, 1'b0);
        drop(0);
        #2 rst_n = 1'b0;
        #1;
        check("t4_rst_sum",   sum0,                  40'd0);
        check("t4_rst_count", {36'b0, cnt0},         40'd0);
        check("t4_rst_valid", {39'b0, out_valid[0]}, 40'd0);
        check("t4_rst_ovf",   {39'b0, out_ovf[0]},   40'd0);
        check("t4_rst_ready", {39'b0, in_ready[0]},  40'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 8; i++) send(0, 32'd3, 1'b0);
        drop(0);
        sb.push_back('{sum: 40'd24, cnt: 4'd8, ovf: 1'b0});
        collect(0, "t4");

        // AW=33 carry-out
        send(1, 32'hFFFF_FFFF, 1'b0);
        send(1, 32'hFFFF_FFFF, 1'b0);
        send(1, 32'h2, 1'b1);
        drop(1);
`ifdef APPROX_ACC_SAT_EN
        sb.push_back('{sum: 40'h1_FFFF_FFFF, cnt: 4'd3, ovf: 1'b1});
`else
        sb.push_back('{sum: 40'h0, cnt: 4'd3, ovf: 1'b1});
`endif
        collect(1, "t5_ovf");
        // Overflow flag cleared for the next frame
        send(1, 32'd5, 1'b1);
        drop(1);
        sb.push_back('{sum: 40'd5, cnt: 4'd1, ovf: 1'b0});
        collect(1, "t5_clear");

        // LEN=1 build: every product ends a frame
        send(2, 32'd42, 1'b0);
        check("t6_latency", {39'b0, out_valid[2]}, 40'd1);
        drop(2);
        sb.push_back('{sum: 40'd42, cnt: 4'd1, ovf: 1'b0});
        collect(2, "t6a");
        send(2, 32'd7, 1'b0);
        drop(2);
        sb.push_back('{sum: 40'd7, cnt: 4'd1, ovf: 1'b0});
        collect(2, "t6b");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
